// File: rtl/ball_link_pkg.sv
// ball_link_pkg
// Shared definitions for the ball hand-off link between the two boards:
// transmit FSM state encoding, the peer's slave register map, the fixed
// commit byte and the frame length for the current build.
//
// Build option: BALL_TX_CHECKSUM_EN inserts an XOR checksum register ahead
// of the commit register, which moves the commit register up by one.
package ball_link_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ISSUE   = 3'd1,
    ST_WAIT    = 3'd2,
    ST_ABORT   = 3'd3,
    ST_BACKOFF = 3'd4,
    ST_DONE    = 3'd5,
    ST_FAIL    = 3'd6
  } tx_state_e;

  // Peer slave register map
  localparam logic [7:0] REG_Y0    = 8'd0;
  localparam logic [7:0] REG_Y1    = 8'd1;
  localparam logic [7:0] REG_VY    = 8'd2;
  localparam logic [7:0] REG_GRAV  = 8'd3;
  localparam logic [7:0] REG_SPEED = 8'd4;
`ifdef BALL_TX_CHECKSUM_EN
  localparam logic [7:0] REG_CKSUM  = 8'd5;
  localparam logic [7:0] REG_COMMIT = 8'd6;
`else
  localparam logic [7:0] REG_COMMIT = 8'd5;
`endif

  // The peer acts on the ball state only once this byte lands, so it is
  // always the final byte of the frame.
  localparam logic [7:0] COMMIT_BYTE = 8'h01;
  // Dummy payload for the STOP-only command used to release the bus.
  localparam logic [7:0] ABORT_BYTE  = 8'hFF;

  // Address byte + register pointer precede the register payload.
  localparam int FRAME_HDR_LEN   = 2;
  localparam int FRAME_LEN_PLAIN = 8;
  localparam int FRAME_LEN_CKSUM = 9;
`ifdef BALL_TX_CHECKSUM_EN
  localparam int FRAME_LEN = FRAME_LEN_CKSUM;
`else
  localparam int FRAME_LEN = FRAME_LEN_PLAIN;
`endif

  localparam int IDX_W = 4;
  typedef logic [IDX_W-1:0] byte_idx_t;

  localparam byte_idx_t IDX_ADDR = 4'd0;
  localparam byte_idx_t IDX_PTR  = 4'd1;
  localparam byte_idx_t IDX_LAST = byte_idx_t'(FRAME_LEN - 1);

`ifdef BALL_TX_CHECKSUM_EN
  function automatic logic [7:0] frame_cksum(input logic [7:0] r0,
                                             input logic [7:0] r1,
                                             input logic [7:0] r2,
                                             input logic [7:0] r3,
                                             input logic [7:0] r4);
    return r0 ^ r1 ^ r2 ^ r3 ^ r4;
  endfunction
`endif

endpackage

// File: rtl/ball_frame_mux.sv
// ball_frame_mux
// Combinational selection of the byte presented to the I2C master for a
// given frame position, plus its START/STOP qualifiers. Built only from the
// latched ball state, so the outputs are stable for as long as the index
// and latched state are held.
//
// Ports:
//   byte_idx     in   frame position (0 = address byte)
//   ball_y       in   latched y position
//   ball_vy      in   latched signed y velocity
//   gravity      in   latched gravity phase
//   fast         in   latched fast flag
//   frame_data   out  byte to shift out
//   frame_start  out  START before this byte
//   frame_stop   out  STOP after this byte
//
// Build option: BALL_TX_CHECKSUM_EN adds the checksum byte.
module ball_frame_mux
  import ball_link_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR = 7'h42
) (
  input  byte_idx_t   byte_idx,
  input  logic [9:0]  ball_y,
  input  logic [7:0]  ball_vy,
  input  logic [1:0]  gravity,
  input  logic        fast,
  output logic [7:0]  frame_data,
  output logic        frame_start,
  output logic        frame_stop
);

  logic [7:0] r0, r1, r2, r3, r4;
  logic [7:0] reg_sel;

  assign r0 = {ball_y[9:8], 6'b0};
  assign r1 = ball_y[7:0];
  assign r2 = ball_vy;
  assign r3 = {6'b0, gravity};
  assign r4 = {7'b0, fast};

  // Payload bytes map one-to-one onto peer registers after the header.
  assign reg_sel = {4'b0, byte_idx - byte_idx_t'(FRAME_HDR_LEN)};

`ifdef BALL_TX_CHECKSUM_EN
  logic [7:0] cksum;
  assign cksum = frame_cksum(r0, r1, r2, r3, r4);
`endif

  always_comb begin
    frame_data  = 8'h00;
    frame_start = 1'b0;
    frame_stop  = 1'b0;
    if (byte_idx == IDX_ADDR) begin
      frame_data  = {SLAVE_ADDR, 1'b0};
      frame_start = 1'b1;
    end else if (byte_idx == IDX_PTR) begin
      frame_data = REG_Y0;
    end else begin
      case (reg_sel)
        REG_Y0:     frame_data = r0;
        REG_Y1:     frame_data = r1;
        REG_VY:     frame_data = r2;
        REG_GRAV:   frame_data = r3;
        REG_SPEED:  frame_data = r4;
`ifdef BALL_TX_CHECKSUM_EN
        REG_CKSUM:  frame_data = cksum;
`endif
        REG_COMMIT: begin
          frame_data = COMMIT_BYTE;
          frame_stop = 1'b1;
        end
        default:    frame_data = 8'h00;
      endcase
    end
  end

endmodule

// File: rtl/ball_tx_i2c_framer.sv
// ball_tx_i2c_framer
// Transmit side of the two-board ball hand-off. On a rising edge of
// ball_send_trigger the ball state is latched and written to the peer's
// register map as one I2C write, one byte command at a time, through a
// byte-level I2C master. NACKs and response timeouts release the bus with a
// STOP-only command, back off, and resend the whole frame; after MAX_RETRY
// retries the transfer is abandoned with tx_fail set. Either way a single
// is_i2c_master_done pulse lets the game controller leave SEND_BALL.
//
// Ports:
//   clk_25MHZ           in   system clock
//   reset               in   asynchronous, active-high
//   ball_send_trigger   in   level, rising edge starts a transfer
//   ball_y/ball_vy/gravity_counter/ball_speed  in  ball state to send
//   cmd_valid/cmd_ready out/in  byte command handshake to the I2C master
//   cmd_start/cmd_stop/cmd_data out  command qualifiers and byte
//   rsp_done/rsp_nack   in   byte completion and slave NACK
//   is_i2c_master_done  out  one-cycle pulse at the end (success or fail)
//   tx_busy             out  transfer in progress
//   tx_fail             out  sticky failure flag, cleared by next trigger
//
// Build option: BALL_TX_CHECKSUM_EN (checksum byte before the commit byte).
//
// state      | meaning
// -----------+----------------------------------------------------------
// ST_IDLE    | waiting for a trigger edge
// ST_ISSUE   | presenting the current frame byte to the master
// ST_WAIT    | byte accepted, waiting for its response (timed)
// ST_ABORT   | sending the STOP-only command, then waiting its response
// ST_BACKOFF | idle gap before resending the frame from the address byte
// ST_DONE    | success pulse
// ST_FAIL    | retries exhausted, failure pulse
module ball_tx_i2c_framer
  import ball_link_pkg::*;
#(
  parameter logic [6:0]  SLAVE_ADDR  = 7'h42,
  parameter logic [19:0] FAST_THRESH = 20'd500000,
  parameter int          MAX_RETRY   = 3,
  parameter int          TIMEOUT_CYC = 250000,
  parameter int          BACKOFF_CYC = 2500
) (
  input  logic        clk_25MHZ,
  input  logic        reset,
  input  logic        ball_send_trigger,
  input  logic [9:0]  ball_y,
  input  logic [7:0]  ball_vy,
  input  logic [1:0]  gravity_counter,
  input  logic [19:0] ball_speed,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic        cmd_start,
  output logic        cmd_stop,
  output logic [7:0]  cmd_data,
  input  logic        rsp_done,
  input  logic        rsp_nack,
  output logic        is_i2c_master_done,
  output logic        tx_busy,
  output logic        tx_fail
);

  localparam int TIMER_W   = $clog2(TIMEOUT_CYC + 1);
  localparam int BACKOFF_W = $clog2(BACKOFF_CYC + 1);
  localparam int RETRY_W   = $clog2(MAX_RETRY + 2);

  localparam logic [TIMER_W-1:0]   TIMER_LAST   = TIMER_W'(TIMEOUT_CYC - 1);
  localparam logic [BACKOFF_W-1:0] BACKOFF_LAST = BACKOFF_W'(BACKOFF_CYC - 1);
  localparam logic [RETRY_W-1:0]   RETRY_LIMIT  = RETRY_W'(MAX_RETRY);

  tx_state_e            state_q, state_d;
  logic                 trig_q, trig_prev_q, trig_edge;
  byte_idx_t            byte_idx_q;
  logic [TIMER_W-1:0]   timer_q;
  logic [BACKOFF_W-1:0] backoff_q;
  logic [RETRY_W-1:0]   retry_q;
  logic                 abort_sent_q;
  logic                 tx_fail_q;

  logic [9:0]           y_q;
  logic [7:0]           vy_q;
  logic [1:0]           grav_q;
  logic                 fast_q;

  logic [7:0]           frame_data;
  logic                 frame_start, frame_stop;

  logic latch_en, idx_inc, idx_clr, timer_clr, abort_issued;
  logic retry_inc, backoff_clr, fail_set;

  // The trigger is registered once before edge detection, which gives the
  // two-cycle trigger-to-first-command latency.
  assign trig_edge = trig_q & ~trig_prev_q;

  ball_frame_mux #(
    .SLAVE_ADDR (SLAVE_ADDR)
  ) u_frame_mux (
    .byte_idx    (byte_idx_q),
    .ball_y      (y_q),
    .ball_vy     (vy_q),
    .gravity     (grav_q),
    .fast        (fast_q),
    .frame_data  (frame_data),
    .frame_start (frame_start),
    .frame_stop  (frame_stop)
  );

  always_ff @(posedge clk_25MHZ or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      trig_q      <= 1'b0;
      trig_prev_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      trig_q      <= ball_send_trigger;
      trig_prev_q <= trig_q;
    end
  end

  always_comb begin
    state_d            = state_q;
    cmd_valid          = 1'b0;
    cmd_start          = 1'b0;
    cmd_stop           = 1'b0;
    cmd_data           = 8'h00;
    is_i2c_master_done = 1'b0;
    latch_en           = 1'b0;
    idx_inc            = 1'b0;
    idx_clr            = 1'b0;
    timer_clr          = 1'b0;
    abort_issued       = 1'b0;
    retry_inc          = 1'b0;
    backoff_clr        = 1'b0;
    fail_set           = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (trig_edge) begin
          latch_en = 1'b1;
          idx_clr  = 1'b1;
          state_d  = ST_ISSUE;
        end
      end

      ST_ISSUE: begin
        // Index and latched state only move on acceptance, so the command
        // holds steady through a ready stall.
        cmd_valid = 1'b1;
        cmd_data  = frame_data;
        cmd_start = frame_start;
        cmd_stop  = frame_stop;
        if (cmd_ready) begin
          timer_clr = 1'b1;
          state_d   = ST_WAIT;
        end
      end

      ST_WAIT: begin
        // A good response wins over a timeout landing on the same cycle.
        if (rsp_done && !rsp_nack) begin
          if (byte_idx_q == IDX_LAST) begin
            state_d = ST_DONE;
          end else begin
            idx_inc = 1'b1;
            state_d = ST_ISSUE;
          end
        end else if (rsp_done || (timer_q == TIMER_LAST)) begin
          state_d = ST_ABORT;
        end
      end

      ST_ABORT: begin
        if (!abort_sent_q) begin
          cmd_valid = 1'b1;
          cmd_stop  = 1'b1;
          cmd_data  = ABORT_BYTE;
          abort_issued = cmd_ready;
        end else if (rsp_done) begin
          if (retry_q < RETRY_LIMIT) begin
            retry_inc   = 1'b1;
            backoff_clr = 1'b1;
            state_d     = ST_BACKOFF;
          end else begin
            fail_set = 1'b1;
            state_d  = ST_FAIL;
          end
        end
      end

      ST_BACKOFF: begin
        if (backoff_q == BACKOFF_LAST) begin
          idx_clr = 1'b1;
          state_d = ST_ISSUE;
        end
      end

      ST_DONE: begin
        is_i2c_master_done = 1'b1;
        state_d            = ST_IDLE;
      end

      ST_FAIL: begin
        is_i2c_master_done = 1'b1;
        state_d            = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_25MHZ or posedge reset) begin
    if (reset) begin
      byte_idx_q   <= IDX_ADDR;
      timer_q      <= '0;
      backoff_q    <= '0;
      retry_q      <= '0;
      abort_sent_q <= 1'b0;
      tx_fail_q    <= 1'b0;
      y_q          <= '0;
      vy_q         <= '0;
      grav_q       <= '0;
      fast_q       <= 1'b0;
    end else begin
      if (latch_en) begin
        y_q    <= ball_y;
        vy_q   <= ball_vy;
        grav_q <= gravity_counter;
        fast_q <= (ball_speed < FAST_THRESH);
      end

      if (idx_clr) begin
        byte_idx_q <= IDX_ADDR;
      end else if (idx_inc) begin
        byte_idx_q <= byte_idx_q + 1'b1;
      end

      if (timer_clr) begin
        timer_q <= '0;
      end else if ((state_q == ST_WAIT) && (timer_q != '1)) begin
        timer_q <= timer_q + 1'b1;
      end

      if (backoff_clr) begin
        backoff_q <= '0;
      end else if ((state_q == ST_BACKOFF) && (backoff_q != '1)) begin
        backoff_q <= backoff_q + 1'b1;
      end

      // retry_inc is only raised below the limit, so this cannot wrap.
      if (latch_en) begin
        retry_q <= '0;
      end else if (retry_inc) begin
        retry_q <= retry_q + 1'b1;
      end

      // Re-armed on every entry to ABORT.
      if (state_q == ST_ABORT) begin
        abort_sent_q <= abort_sent_q | abort_issued;
      end else begin
        abort_sent_q <= 1'b0;
      end

      // Set on the way into FAIL so it is already high during the pulse.
      if (latch_en) begin
        tx_fail_q <= 1'b0;
      end else if (fail_set) begin
        tx_fail_q <= 1'b1;
      end
    end
  end

  assign tx_busy = (state_q != ST_IDLE);
  assign tx_fail = tx_fail_q;

endmodule

// File: tb/tb_ball_tx_i2c_framer.sv
module tb_ball_tx_i2c_framer;

  localparam int TB_TIMEOUT = 64;
  localparam int TB_BACKOFF = 16;
  localparam int TB_RETRY   = 3;
`ifdef BALL_TX_CHECKSUM_EN
  localparam int FLEN = 9;
`else
  localparam int FLEN = 8;
`endif

  logic        clk_25MHZ = 1'b0;
  logic        reset = 1'b1;
  logic        ball_send_trigger = 1'b0;
  logic [9:0]  ball_y = '0;
  logic [7:0]  ball_vy = '0;
  logic [1:0]  gravity_counter = '0;
  logic [19:0] ball_speed = '0;
  logic        cmd_valid, cmd_start, cmd_stop;
  logic [7:0]  cmd_data;
  logic        cmd_ready, rsp_done, rsp_nack;
  logic        is_i2c_master_done, tx_busy, tx_fail;

  int checks = 0;
  int errors = 0;

  // Master model controls and scoreboard
  int         m_stall;
  int         m_nack_mode;   // 0 none, 1 nack first address byte, 2 nack all
  bit         m_withhold;
  int         m_addr_seen;
  int         m_unstable;
  int         m_stall_seen;
  int         m_first_gap;
  int         m_backoff_gap;
  int         m_done_cnt;
  logic       m_fail_at_done;
  logic [9:0] log_q[$];      // {start, stop, data}

  logic [7:0] exp_frame [FLEN];

  ball_tx_i2c_framer #(
    .SLAVE_ADDR  (7'h42),
    .FAST_THRESH (20'd500000),
    .MAX_RETRY   (TB_RETRY),
    .TIMEOUT_CYC (TB_TIMEOUT),
    .BACKOFF_CYC (TB_BACKOFF)
  ) dut (
    .clk_25MHZ          (clk_25MHZ),
    .reset              (reset),
    .ball_send_trigger  (ball_send_trigger),
    .ball_y             (ball_y),
    .ball_vy            (ball_vy),
    .gravity_counter    (gravity_counter),
    .ball_speed         (ball_speed),
    .cmd_valid          (cmd_valid),
    .cmd_ready          (cmd_ready),
    .cmd_start          (cmd_start),
    .cmd_stop           (cmd_stop),
    .cmd_data           (cmd_data),
    .rsp_done           (rsp_done),
    .rsp_nack           (rsp_nack),
    .is_i2c_master_done (is_i2c_master_done),
    .tx_busy            (tx_busy),
    .tx_fail            (tx_fail)
  );

  always #20 clk_25MHZ = ~clk_25MHZ;

  // Byte-level I2C master model
  initial begin
    logic [7:0] d0;
    logic       s0, p0;
    bit         is_abort;
    int         gap;
    cmd_ready = 1'b0;
    rsp_done  = 1'b0;
    rsp_nack  = 1'b0;
    forever begin
      @(posedge clk_25MHZ); #1;
      while (cmd_valid === 1'b1) begin
        d0 = cmd_data; s0 = cmd_start; p0 = cmd_stop;
        for (int s = 0; s < m_stall; s++) begin
          @(posedge clk_25MHZ); #1;
          m_stall_seen++;
          if (cmd_valid !== 1'b1 || cmd_data !== d0 || cmd_start !== s0 || cmd_stop !== p0)
            m_unstable++;
        end
        cmd_ready = 1'b1;
        @(posedge clk_25MHZ); #1;
        cmd_ready = 1'b0;
        log_q.push_back({s0, p0, d0});
        is_abort = (s0 == 1'b0) && (p0 == 1'b1) && (d0 == 8'hFF);
        if (s0) m_addr_seen++;
        if (!is_abort && m_withhold) begin
          gap = 0;
          while (cmd_valid !== 1'b1 && gap < 1000) begin
            @(posedge clk_25MHZ); #1;
            gap++;
          end
          if (m_first_gap < 0) m_first_gap = gap;
        end else begin
          rsp_done = 1'b1;
          if (is_abort) rsp_nack = (m_nack_mode == 2);
          else rsp_nack = s0 && ((m_nack_mode == 2) || (m_nack_mode == 1 && m_addr_seen == 1));
          @(posedge clk_25MHZ); #1;
          rsp_done = 1'b0;
          rsp_nack = 1'b0;
          if (is_abort) begin
            gap = 0;
            while (cmd_valid !== 1'b1 && tx_busy === 1'b1 && gap < 1000) begin
              @(posedge clk_25MHZ); #1;
              gap++;
            end
            if (m_backoff_gap < 0 && tx_busy === 1'b1) m_backoff_gap = gap;
          end
        end
      end
    end
  end

  // Done pulse monitor
  initial begin
    forever begin
      @(negedge clk_25MHZ);
      if (is_i2c_master_done === 1'b1) begin
        m_done_cnt++;
        m_fail_at_done = tx_fail;
      end
    end
  end

  initial begin
    #(40 * 60000);
    $display("FAIL watchdog: simulation did not finish, got timeout required summary");
    $fatal(1);
  end

  task automatic clear_sb();
    log_q.delete();
    m_addr_seen    = 0;
    m_unstable     = 0;
    m_stall_seen   = 0;
    m_first_gap    = -1;
    m_backoff_gap  = -1;
    m_done_cnt     = 0;
    m_fail_at_done = 1'bx;
  endtask

  task automatic set_ball(input logic [9:0] y, input logic [7:0] vy,
                          input logic [1:0] g, input logic [19:0] spd);
    ball_y = y; ball_vy = vy; gravity_counter = g; ball_speed = spd;
  endtask

  task automatic wait_done(input int budget, input string name);
    int n = 0;
    while (m_done_cnt == 0 && n < budget) begin
      @(posedge clk_25MHZ); #1;
      n++;
    end
    checks++;
    if (m_done_cnt == 0) begin
      errors++;
      $display("FAIL %s_done_wait: got no done pulse in %0d cycles, required one", name, budget);
    end
    repeat (4) @(posedge clk_25MHZ);
    #1;
  endtask

  task automatic drop_trigger();
    ball_send_trigger = 1'b0;
    repeat (3) @(posedge clk_25MHZ);
    #1;
  endtask

  task automatic fire(input int budget, input string name);
    ball_send_trigger = 1'b1;
    wait_done(budget, name);
    drop_trigger();
  endtask

  task automatic test_reset();
    @(posedge clk_25MHZ); #1;
    checks++;
    if ({cmd_valid, cmd_start, cmd_stop, is_i2c_master_done, tx_busy, tx_fail} !== 6'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b required 000000",
               {cmd_valid, cmd_start, cmd_stop, is_i2c_master_done, tx_busy, tx_fail});
    end
    checks++;
    if (cmd_data !== 8'h00) begin
      errors++;
      $display("FAIL reset_data: got %02h required 00", cmd_data);
    end
    repeat (2) @(posedge clk_25MHZ);
    #2 reset = 1'b0;
    repeat (3) @(posedge clk_25MHZ);
    #1;
    checks++;
    if ({cmd_valid, tx_busy, tx_fail, is_i2c_master_done} !== 4'b0) begin
      errors++;
      $display("FAIL reset_release: got %b required 0000",
               {cmd_valid, tx_busy, tx_fail, is_i2c_master_done});
    end
  endtask

  task automatic test_basic_frame();
    int lat;
    clear_sb();
    m_stall = 0; m_nack_mode = 0; m_withhold = 0;
    set_ball(10'h2A5, 8'hFD, 2'd2, 20'd600000);
    ball_send_trigger = 1'b1;
    lat = 0;
    while (cmd_valid !== 1'b1 && lat < 20) begin
      @(posedge clk_25MHZ); #1;
      lat++;
    end
    checks++;
    if (lat != 2) begin
      errors++;
      $display("FAIL basic_latency: got %0d cycles required 2", lat);
    end
    wait_done(200, "basic");
    drop_trigger();
    checks++;
    if (log_q.size() != FLEN) begin
      errors++;
      $display("FAIL basic_len: got %0d bytes required %0d", log_q.size(), FLEN);
    end
    for (int i = 0; i < FLEN; i++) begin
      checks++;
      if (log_q[i][7:0] !== exp_frame[i]) begin
        errors++;
        $display("FAIL basic_byte[%0d]: got %02h required %02h", i, log_q[i][7:0], exp_frame[i]);
      end
      checks++;
      if (log_q[i][9] !== (i == 0)) begin
        errors++;
        $display("FAIL basic_start[%0d]: got %b required %b", i, log_q[i][9], (i == 0));
      end
      checks++;
      if (log_q[i][8] !== (i == FLEN - 1)) begin
        errors++;
        $display("FAIL basic_stop[%0d]: got %b required %b", i, log_q[i][8], (i == FLEN - 1));
      end
    end
    checks++;
    if (m_done_cnt != 1) begin
      errors++;
      $display("FAIL basic_done_count: got %0d required 1", m_done_cnt);
    end
    checks++;
    if (tx_fail !== 1'b0 || m_fail_at_done !== 1'b0) begin
      errors++;
      $display("FAIL basic_tx_fail: got %b/%b required 0/0", tx_fail, m_fail_at_done);
    end
  endtask

  task automatic test_fast_flag();
    clear_sb();
    set_ball(10'h2A5, 8'hFD, 2'd2, 20'd400000);
    fire(200, "fast400k");
    checks++;
    if (log_q[6][7:0] !== 8'h01) begin
      errors++;
      $display("FAIL fast_400k: got R4=%02h required 01", log_q[6][7:0]);
    end
    clear_sb();
    set_ball(10'h2A5, 8'hFD, 2'd2, 20'd500000);
    fire(200, "fast500k");
    checks++;
    if (log_q[6][7:0] !== 8'h00) begin
      errors++;
      $display("FAIL fast_500k: got R4=%02h required 00", log_q[6][7:0]);
    end
  endtask

  task automatic test_nack_retry();
    clear_sb();
    m_nack_mode = 1;
    set_ball(10'h2A5, 8'hFD, 2'd2, 20'd600000);
    fire(500, "nack_retry");
    m_nack_mode = 0;
    checks++;
    if (log_q.size() != FLEN + 2) begin
      errors++;
      $display("FAIL nack_len: got %0d commands required %0d", log_q.size(), FLEN + 2);
    end
    checks++;
    if (log_q[0] !== 10'h284) begin
      errors++;
      $display("FAIL nack_first: got %03h required 284", log_q[0]);
    end
    checks++;
    if (log_q[1] !== 10'h1FF) begin
      errors++;
      $display("FAIL nack_abort_cmd: got %03h required 1FF", log_q[1]);
    end
    for (int i = 0; i < FLEN; i++) begin
      checks++;
      if (log_q[i + 2][7:0] !== exp_frame[i]) begin
        errors++;
        $display("FAIL nack_resend[%0d]: got %02h required %02h", i, log_q[i + 2][7:0], exp_frame[i]);
      end
    end
    checks++;
    if (m_backoff_gap != TB_BACKOFF) begin
      errors++;
      $display("FAIL nack_backoff: got %0d idle cycles required %0d", m_backoff_gap, TB_BACKOFF);
    end
    checks++;
    if (m_done_cnt != 1 || tx_fail !== 1'b0) begin
      errors++;
      $display("FAIL nack_result: got done=%0d fail=%b required done=1 fail=0", m_done_cnt, tx_fail);
    end
  endtask

  task automatic test_retry_exhaust();
    clear_sb();
    m_nack_mode = 2;
    fire(2000, "exhaust");
    m_nack_mode = 0;
    checks++;
    if (log_q.size() != 8) begin
      errors++;
      $display("FAIL exhaust_len: got %0d commands required 8", log_q.size());
    end
    for (int a = 0; a < 4; a++) begin
      checks++;
      if (log_q[2 * a] !== 10'h284 || log_q[2 * a + 1] !== 10'h1FF) begin
        errors++;
        $display("FAIL exhaust_attempt[%0d]: got %03h,%03h required 284,1FF",
                 a, log_q[2 * a], log_q[2 * a + 1]);
      end
    end
    checks++;
    if (m_done_cnt != 1 || m_fail_at_done !== 1'b1) begin
      errors++;
      $display("FAIL exhaust_done: got done=%0d fail_at_done=%b required 1/1", m_done_cnt, m_fail_at_done);
    end
    repeat (5) @(posedge clk_25MHZ);
    #1;
    checks++;
    if (tx_fail !== 1'b1) begin
      errors++;
      $display("FAIL exhaust_sticky: got tx_fail=%b required 1", tx_fail);
    end
    clear_sb();
    ball_send_trigger = 1'b1;
    repeat (3) @(posedge clk_25MHZ);
    #1;
    checks++;
    if (tx_fail !== 1'b0) begin
      errors++;
      $display("FAIL exhaust_clear: got tx_fail=%b required 0 after trigger", tx_fail);
    end
    wait_done(200, "exhaust_clear");
    drop_trigger();
    checks++;
    if (tx_fail !== 1'b0 || log_q.size() != FLEN) begin
      errors++;
      $display("FAIL exhaust_recover: got fail=%b len=%0d required 0/%0d", tx_fail, log_q.size(), FLEN);
    end
  endtask

  task automatic test_timeout_stall();
    clear_sb();
    m_stall = 5; m_withhold = 1;
    fire(3000, "timeout");
    m_stall = 0; m_withhold = 0;
    checks++;
    if (m_unstable != 0) begin
      errors++;
      $display("FAIL stall_stable: got %0d unstable samples required 0", m_unstable);
    end
    checks++;
    if (m_stall_seen != 40) begin
      errors++;
      $display("FAIL stall_cycles: got %0d stalled samples required 40", m_stall_seen);
    end
    checks++;
    if (m_first_gap != TB_TIMEOUT) begin
      errors++;
      $display("FAIL timeout_len: got %0d cycles in WAIT required %0d", m_first_gap, TB_TIMEOUT);
    end
    checks++;
    if (log_q.size() != 8 || tx_fail !== 1'b1) begin
      errors++;
      $display("FAIL timeout_result: got len=%0d fail=%b required 8/1", log_q.size(), tx_fail);
    end
  endtask

  task automatic test_trigger_hold();
    int starts = 0;
    clear_sb();
    ball_send_trigger = 1'b1;
    repeat (1000) @(posedge clk_25MHZ);
    #1;
    drop_trigger();
    foreach (log_q[i]) if (log_q[i][9]) starts++;
    checks++;
    if (starts != 1 || m_done_cnt != 1) begin
      errors++;
      $display("FAIL hold_single: got starts=%0d done=%0d required 1/1", starts, m_done_cnt);
    end
  endtask

  task automatic test_reset_mid();
    bit found = 0;
    clear_sb();
    m_stall = 4;
    set_ball(10'h2A5, 8'hFD, 2'd2, 20'd600000);
    ball_send_trigger = 1'b1;
    for (int n = 0; n < 200 && !found; n++) begin
      @(posedge clk_25MHZ); #3;
      if (log_q.size() == 4 && cmd_valid === 1'b1 && cmd_data === 8'hFD) found = 1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL reset_mid_reach: got no R2 issue required R2 pending");
    end
    reset = 1'b1;
    ball_send_trigger = 1'b0;
    @(posedge clk_25MHZ); #1;
    checks++;
    if ({cmd_valid, cmd_start, cmd_stop, is_i2c_master_done, tx_busy, tx_fail} !== 6'b0
        || cmd_data !== 8'h00) begin
      errors++;
      $display("FAIL reset_mid_outputs: got %b data %02h required 000000 data 00",
               {cmd_valid, cmd_start, cmd_stop, is_i2c_master_done, tx_busy, tx_fail}, cmd_data);
    end
    repeat (10) @(posedge clk_25MHZ);
    #3 reset = 1'b0;
    repeat (3) @(posedge clk_25MHZ);
    #1;
    m_stall = 0;
    checks++;
    if (tx_busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_idle: got tx_busy=%b required 0", tx_busy);
    end
    clear_sb();
    fire(200, "reset_recover");
    checks++;
    if (log_q.size() != FLEN || log_q[0] !== 10'h284) begin
      errors++;
      $display("FAIL reset_mid_recover: got len=%0d first=%03h required %0d/284", log_q.size(), log_q[0], FLEN);
    end
  endtask

  initial begin
`ifdef BALL_TX_CHECKSUM_EN
    exp_frame = '{8'h84, 8'h00, 8'h80, 8'hA5, 8'hFD, 8'h02, 8'h00, 8'hDA, 8'h01};
`else
    exp_frame = '{8'h84, 8'h00, 8'h80, 8'hA5, 8'hFD, 8'h02, 8'h00, 8'h01};
`endif
    m_stall = 0; m_nack_mode = 0; m_withhold = 0;
    clear_sb();
    test_reset();
    test_basic_frame();
    test_fast_flag();
    test_nack_retry();
    test_retry_exhaust();
    test_timeout_stall();
    test_trigger_hold();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
